counter_load_ctrl: RTL

//  Upstream controller for the 4-bit loadable counter. Drives its load/load_data pins and monitors its count.

---
 rtl/counter_load_ctrl.sv | 115 +++++++++++
 1 files changed

// File: rtl/counter_load_ctrl.sv
// counter_load_ctrl: upstream controller for an N-bit loadable counter.
// Runs start->end sequences, either one-shot or auto-reload, and drives the
// counter's load/load_data pins. When idle it holds the counter by reloading
// the counter's own value, because the counter increments whenever load=0.
module counter_load_ctrl #(
    parameter int unsigned N = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         cfg_valid,
    output logic         cfg_ready,
    input  logic [N-1:0] cfg_start,
    input  logic [N-1:0] cfg_end,
    input  logic         cfg_reload,
    input  logic         abort,
    input  logic [N-1:0] count,
    output logic         load,
    output logic [N-1:0] load_data,
    output logic         busy,
    output logic         tc,
    output logic         done
);

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StPreset = 2'd1,
        StRun    = 2'd2
    } state_e;

    state_e       r_state;
    logic [N-1:0] r_start;
    logic [N-1:0] r_end;
    logic         r_reload;

    logic         w_accept;
    logic         w_at_end;

    assign w_accept = cfg_valid && cfg_ready;
    assign w_at_end = (count == r_end);

    // State and latched configuration; config is captured only on accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= StIdle;
            r_start  <= '0;
            r_end    <= '0;
            r_reload <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_accept) begin
                        r_start  <= cfg_start;
                        r_end    <= cfg_end;
                        r_reload <= cfg_reload;
                        r_state  <= StPreset;
                    end
                end
                // abort is ignored here; the start value must reach the counter.
                StPreset: begin
                    r_state <= StRun;
                end
                StRun: begin
                    if (abort) begin
                        r_state <= StIdle;
                    end else if (w_at_end && !r_reload) begin
                        r_state <= StIdle;
                    end
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    // Counter control and status, combinational from state, count and abort.
    always_comb begin
        load      = 1'b1;
        load_data = count;
        tc        = 1'b0;
        done      = 1'b0;
        cfg_ready = 1'b0;
        busy      = 1'b1;
        unique case (r_state)
            StIdle: begin
                cfg_ready = 1'b1;
                busy      = 1'b0;
            end
            StPreset: begin
                load_data = r_start;
            end
            StRun: begin
                if (abort) begin
                    // Abort wins over terminal count: freeze the current value.
                    load_data = count;
                end else if (w_at_end) begin
                    tc = 1'b1;
                    if (r_reload) begin
                        load_data = r_start;
                    end else begin
                        // Reloading end keeps the counter parked on the final value.
                        load_data = r_end;
                        done      = 1'b1;
                    end
                end else begin
                    load = 1'b0;
                end
            end
            default: begin
                cfg_ready = 1'b0;
            end
        endcase
    end

endmodule
